// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the handshaking multi-cycle control unit.
// Holds FSM state codes, ALU op codes, PC/RegDst mux codes, opcodes and the
// decoded-instruction record passed from mc_op_decode to mc_ctrl_hs.
package mc_pkg;

  // FSM state encodings (also visible on the debug state port)
  localparam logic [2:0] ST_IF    = 3'b000;
  localparam logic [2:0] ST_ID    = 3'b001;
  localparam logic [2:0] ST_EXE   = 3'b010;
  localparam logic [2:0] ST_MEM   = 3'b011;
  localparam logic [2:0] ST_WB    = 3'b100;
  localparam logic [2:0] ST_HALT  = 3'b101;
  localparam logic [2:0] ST_FAULT = 3'b110;

  // ALU function codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // PC source select
  localparam logic [1:0] PCS_NEXT = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JR   = 2'b10;
  localparam logic [1:0] PCS_JMP  = 2'b11;

  // Register destination select
  localparam logic [1:0] RDST_RA = 2'b00;
  localparam logic [1:0] RDST_RT = 2'b01;
  localparam logic [1:0] RDST_RD = 2'b10;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Instruction classes: each class follows one fixed path through the FSM
  typedef enum logic [3:0] {
    CL_UNDEF = 4'd0,
    CL_RTYPE = 4'd1,
    CL_IMM   = 4'd2,
    CL_LW    = 4'd3,
    CL_SW    = 4'd4,
    CL_BEQ   = 4'd5,
    CL_BNE   = 4'd6,
    CL_BLTZ  = 4'd7,
    CL_J     = 4'd8,
    CL_JAL   = 4'd9,
    CL_JR    = 4'd10,
    CL_HALT  = 4'd11
  } op_class_t;

  // Static per-opcode decode
  typedef struct packed {
    op_class_t  cls;
    logic [2:0] alu_op;
    logic       extsel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] reg_dst;
  } dec_t;

  function automatic logic is_branch(input op_class_t c);
    return (c == CL_BEQ) || (c == CL_BNE) || (c == CL_BLTZ);
  endfunction

endpackage

// File: rtl/mc_op_decode.sv
// mc_op_decode: purely combinational opcode decoder.
// Ports: op (opcode from IR) in; dec (class + ALUOp/Extsel/ALUSrcA/B/RegDst) out.
// Undefined opcodes decode to CL_UNDEF with all selects zero.
module mc_op_decode
  import mc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_ADD:   begin dec.cls = CL_RTYPE; dec.alu_op = ALU_ADD; dec.reg_dst = RDST_RD; end
      OP_SUB:   begin dec.cls = CL_RTYPE; dec.alu_op = ALU_SUB; dec.reg_dst = RDST_RD; end
      OP_AND:   begin dec.cls = CL_RTYPE; dec.alu_op = ALU_AND; dec.reg_dst = RDST_RD; end
      OP_OR:    begin dec.cls = CL_RTYPE; dec.alu_op = ALU_OR;  dec.reg_dst = RDST_RD; end
      OP_SLT:   begin dec.cls = CL_RTYPE; dec.alu_op = ALU_SLT; dec.reg_dst = RDST_RD; end
      OP_SLL: begin
        dec.cls       = CL_RTYPE;
        dec.alu_op    = ALU_SLL;
        dec.alu_src_a = 1'b1;      // shift amount comes from shamt
        dec.reg_dst   = RDST_RD;
      end
      OP_ADDIU: begin
        dec.cls = CL_IMM; dec.alu_op = ALU_ADD; dec.extsel = 1'b1;
        dec.alu_src_b = 1'b1; dec.reg_dst = RDST_RT;
      end
      OP_ANDI: begin
        dec.cls = CL_IMM; dec.alu_op = ALU_AND;
        dec.alu_src_b = 1'b1; dec.reg_dst = RDST_RT;
      end
      OP_ORI: begin
        dec.cls = CL_IMM; dec.alu_op = ALU_OR;
        dec.alu_src_b = 1'b1; dec.reg_dst = RDST_RT;
      end
      OP_SLTI: begin
        dec.cls = CL_IMM; dec.alu_op = ALU_SLT; dec.extsel = 1'b1;
        dec.alu_src_b = 1'b1; dec.reg_dst = RDST_RT;
      end
      OP_LW: begin
        dec.cls = CL_LW; dec.alu_op = ALU_ADD; dec.extsel = 1'b1;
        dec.alu_src_b = 1'b1; dec.reg_dst = RDST_RT;
      end
      OP_SW: begin
        dec.cls = CL_SW; dec.alu_op = ALU_ADD; dec.extsel = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      OP_BEQ:  begin dec.cls = CL_BEQ;  dec.alu_op = ALU_SUB; dec.extsel = 1'b1; end
      OP_BNE:  begin dec.cls = CL_BNE;  dec.alu_op = ALU_SUB; dec.extsel = 1'b1; end
      // bltz compares rs against $0 with slt; the ALU sign bit decides
      OP_BLTZ: begin dec.cls = CL_BLTZ; dec.alu_op = ALU_SLT; dec.extsel = 1'b1; end
      OP_J:    dec.cls = CL_J;
      OP_JAL:  dec.cls = CL_JAL;
      OP_JR:   dec.cls = CL_JR;
      OP_HALT: dec.cls = CL_HALT;
      default: dec.cls = CL_UNDEF;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multi-cycle MIPS-subset control FSM with imem/dmem wait-state
// handshakes, a wait watchdog, sticky FAULT and HALT states.
// Ports: CLK/RST, Op/zero/sign/acks in; datapath strobes, mux selects, state/fault/halted out.
module mc_ctrl_hs
  import mc_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    Op,
  input  logic               zero,
  input  logic               sign,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               Extsel,
  output logic               InsMemRW,
  output logic               WrRegDSrc,
  output logic [1:0]         RegDst,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSrc,
  output logic               RD,
  output logic               WR,
  output logic               DBDataSrc,
  output logic [2:0]         state,
  output logic               fault,
  output logic               halted
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  logic [2:0]       state_q;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_tmo;
  logic             taken;
  dec_t             dec;

  mc_op_decode #(.OP_W(OP_W)) u_dec (
    .op  (Op),
    .dec (dec)
  );

  assign state    = state_q;
  // Counter already at the limit and still no ack: this cycle is the last allowed wait
  assign wait_tmo = (wait_cnt == WAIT_LIM);
  assign taken    = ((dec.cls == CL_BEQ)  &&  zero) ||
                    ((dec.cls == CL_BNE)  && !zero) ||
                    ((dec.cls == CL_BLTZ) &&  sign);

  // Outputs are gated by RST directly so a reset mid-cycle kills any strobe at once
  always_comb begin
    next_state = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    PCWre      = 1'b0;
    IRWre      = 1'b0;
    RegWre     = 1'b0;
    Extsel     = 1'b0;
    InsMemRW   = 1'b0;
    WrRegDSrc  = 1'b0;
    RegDst     = RDST_RA;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 1'b0;
    ALUOp      = '0;
    PCSrc      = PCS_NEXT;
    RD         = 1'b0;
    WR         = 1'b0;
    DBDataSrc  = 1'b0;
    fault      = 1'b0;
    halted     = 1'b0;

    if (!RST) begin
      InsMemRW  = 1'b1;
      WrRegDSrc = 1'b1;
      Extsel    = dec.extsel;
      ALUSrcA   = dec.alu_src_a;
      ALUSrcB   = dec.alu_src_b;
      ALUOp     = ALUOP_W'(dec.alu_op);

      case (state_q)
        ST_IF: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            IRWre      = 1'b1;
            next_state = ST_ID;
          end else if (wait_tmo) begin
            next_state = ST_FAULT;
          end
        end

        ST_ID: begin
          case (dec.cls)
            CL_HALT:  next_state = ST_HALT;
            CL_UNDEF: next_state = ST_FAULT;
            CL_J: begin
              PCWre      = 1'b1;
              PCSrc      = PCS_JMP;
              next_state = ST_IF;
            end
            CL_JAL: begin
              PCWre      = 1'b1;
              PCSrc      = PCS_JMP;
              RegWre     = 1'b1;
              RegDst     = RDST_RA;
              WrRegDSrc  = 1'b0;   // link value is PC+4
              next_state = ST_IF;
            end
            CL_JR: begin
              PCWre      = 1'b1;
              PCSrc      = PCS_JR;
              next_state = ST_IF;
            end
            default:  next_state = ST_EXE;
          endcase
        end

        ST_EXE: begin
          if (is_branch(dec.cls)) begin
            PCWre      = 1'b1;
            PCSrc      = taken ? PCS_BR : PCS_NEXT;
            next_state = ST_IF;
          end else if ((dec.cls == CL_LW) || (dec.cls == CL_SW)) begin
            next_state = ST_MEM;
          end else begin
            next_state = ST_WB;
          end
        end

        ST_MEM: begin
          dmem_req = 1'b1;
          RD       = (dec.cls == CL_LW);
          WR       = (dec.cls == CL_SW);
          if (dmem_ack) begin
            if (dec.cls == CL_SW) begin
              PCWre      = 1'b1;
              next_state = ST_IF;
            end else begin
              next_state = ST_WB;
            end
          end else if (wait_tmo) begin
            next_state = ST_FAULT;
          end
        end

        ST_WB: begin
          RegWre     = 1'b1;
          PCWre      = 1'b1;
          PCSrc      = PCS_NEXT;
          DBDataSrc  = (dec.cls == CL_LW);
          RegDst     = dec.reg_dst;
          next_state = ST_IF;
        end

        ST_HALT:  halted = 1'b1;
        ST_FAULT: fault  = 1'b1;
        // Unused encoding can only come from an upset; park it in FAULT
        default:  next_state = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IF;
    end else begin
      state_q <= next_state;
    end
  end

  // Counts consecutive cycles spent waiting in IF or MEM; any transition clears it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (next_state != state_q) begin
      wait_cnt <= '0;
    end else if ((state_q == ST_IF) || (state_q == ST_MEM)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
